// File: rtl/irom_arb_pkg.sv
// Shared types and constants for the instruction-ROM fetch arbiter.
package irom_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   localparam int STARVE_MIN = 1;
   localparam int STARVE_LIM = 15;
   localparam int STARVE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } arb_state_t;

   function automatic int starve_clamp(input int v);
      if (v < STARVE_MIN) return STARVE_MIN;
      if (v > STARVE_LIM) return STARVE_LIM;
      return v;
   endfunction

endpackage

// File: rtl/irom_arb_fifo2.sv
// Two-entry synchronous FIFO carrying debug burst words.
module irom_arb_fifo2
   import irom_arb_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != 2'd2) | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/irom_fetch_arbiter.sv
// Shares one combinational instruction ROM between CPU fetch (priority)
// and a starvation-protected debug burst reader with a 2-deep output buffer.
module irom_fetch_arbiter
   import irom_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_data,
   output logic              cpu_valid,
   input  logic              dbg_start,
   input  logic [ADDR_W-1:0] dbg_base,
   input  logic [ADDR_W:0]   dbg_len,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_valid,
   input  logic              dbg_ready,
   output logic              dbg_busy,
   output logic              dbg_done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   localparam logic [STARVE_W-1:0] STARVE_TOP =
      STARVE_W'(starve_clamp(STARVE_MAX));
   localparam logic [ADDR_W:0]     REM_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0]   PTR_ONE = ADDR_W'(1);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [ADDR_W-1:0]   dbg_ptr;
   logic [ADDR_W:0]     remaining;
   logic [STARVE_W-1:0] starve_cnt;
   logic [1:0]          count;
   logic                zero_done;
   logic                zero_start;
   logic                drain_done;
   logic                load;
   logic                pop;
   logic                dbg_want;
   logic                dbg_grant;
   logic                cpu_grant;

   assign dbg_valid = (count != 2'd0);
   assign pop       = dbg_valid & dbg_ready;

   // A full buffer may still take a word if it is draining this cycle.
   assign dbg_want  = (state_q == FETCH) & (remaining != '0)
                    & ((count != 2'd2) | pop);
   assign dbg_grant = dbg_want & (~cpu_req | (starve_cnt == STARVE_TOP));
   assign cpu_grant = cpu_req & ~dbg_grant;
   assign cpu_stall = cpu_req & ~cpu_grant;
   assign rom_addr  = dbg_grant ? dbg_ptr : cpu_addr;
   assign dbg_busy  = (state_q != IDLE);
   assign dbg_done  = drain_done | zero_done;

   irom_arb_fifo2 #(
      .W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dbg_grant),
      .pop   (pop),
      .wdata (rom_data),
      .rdata (dbg_data),
      .count (count)
   );

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      zero_start = 1'b0;
      drain_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dbg_start) begin
               if (dbg_len != '0) begin
                  load    = 1'b1;
                  state_d = FETCH;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         FETCH: begin
            if (dbg_grant && remaining == REM_ONE) state_d = DRAIN;
         end
         DRAIN: begin
            if (count == 2'd0) begin
               drain_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         starve_cnt <= '0;
         zero_done  <= 1'b0;
         cpu_valid  <= 1'b0;
         cpu_data   <= '0;
         dbg_ptr    <= '0;
         remaining  <= '0;
      end else begin
         state_q   <= state_d;
         zero_done <= zero_start;
         cpu_valid <= cpu_grant;
         if (cpu_grant) cpu_data <= rom_data;
         if (load) begin
            dbg_ptr   <= dbg_base;
            remaining <= dbg_len;
         end else if (dbg_grant) begin
            dbg_ptr   <= dbg_ptr + PTR_ONE;
            remaining <= remaining - REM_ONE;
         end
         if (dbg_grant)
            starve_cnt <= '0;
         else if (dbg_want && cpu_grant)
            starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

endmodule

// File: tb/tb_irom_fetch_arbiter.sv
// Scoreboard bench for irom_fetch_arbiter with a behavioural ROM.
module tb_irom_fetch_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_stall;
   logic [DW-1:0] cpu_data;
   logic          cpu_valid;
   logic          dbg_start = 1'b0;
   logic [AW-1:0] dbg_base = '0;
   logic [AW:0]   dbg_len = '0;
   logic [DW-1:0] dbg_data;
   logic          dbg_valid;
   logic          dbg_ready = 1'b0;
   logic          dbg_busy;
   logic          dbg_done;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   logic [DW-1:0] cpu_q [$];
   logic [DW-1:0] dbg_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [9:0] a);
      case (a)
         10'd0:   return 32'd538772480;
         10'd1:   return 32'd537985031;
         10'd2:   return 32'd538116127;
         10'd5:   return 32'd538312848;
         10'd6:   return 32'd202375420;
         10'd7:   return 32'd202375394;
         default: return {12'hABC, 10'd0, a};
      endcase
   endfunction

   assign rom_data = rom_f(rom_addr);

   irom_fetch_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_stall (cpu_stall),
      .cpu_data  (cpu_data),
      .cpu_valid (cpu_valid),
      .dbg_start (dbg_start),
      .dbg_base  (dbg_base),
      .dbg_len   (dbg_len),
      .dbg_data  (dbg_data),
      .dbg_valid (dbg_valid),
      .dbg_ready (dbg_ready),
      .dbg_busy  (dbg_busy),
      .dbg_done  (dbg_done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (dbg_done) break;
         if (n >= bound) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no dbg_done expected within %0d", bound);
            break;
         end
      end
   endtask

   task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
      step();
      dbg_start = 1'b1;
      dbg_base  = b;
      dbg_len   = l;
      step();
      dbg_start = 1'b0;
   endtask

   // Monitor: pops the expected word whenever the DUT hands one out.
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_valid) begin
            if (cpu_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL cpu_extra: got word %0d expected none", cpu_data);
            end else begin
               check("cpu_data", cpu_data, cpu_q.pop_front());
            end
         end
         if (dbg_valid && dbg_ready) begin
            if (dbg_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL dbg_extra: got word %0d expected none", dbg_data);
            end else begin
               check("dbg_data", dbg_data, dbg_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end

   initial begin
      int n;
      logic exp_stall;

      // reset values
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      check("rst_cpu_valid", cpu_valid, 0);
      check("rst_cpu_data", cpu_data, 0);
      check("rst_dbg_valid", dbg_valid, 0);
      check("rst_dbg_data", dbg_data, 0);
      check("rst_dbg_busy", dbg_busy, 0);
      check("rst_dbg_done", dbg_done, 0);
      step();
      rst = 1'b0;

      // CPU only, back-to-back
      for (int i = 0; i < 3; i++) begin
         step();
         cpu_req  = 1'b1;
         cpu_addr = AW'(i);
         cpu_q.push_back(rom_f(AW'(i)));
         @(negedge clk);
         check("cpu_only_stall", cpu_stall, 0);
      end
      step();
      cpu_req = 1'b0;
      step();
      @(negedge clk);
      check("cpu_idle_valid", cpu_valid, 0);

      // Debug only, base 5 len 3
      dbg_ready = 1'b1;
      dbg_q.push_back(32'd538312848);
      dbg_q.push_back(32'd202375420);
      dbg_q.push_back(32'd202375394);
      start_burst(10'd5, 11'd3);
      wait_done(20, n);
      check("dbg_done_latency", n, 5);
      check("dbg_busy_at_done", dbg_busy, 1);
      @(negedge clk);
      check("dbg_busy_after", dbg_busy, 0);
      check("dbg_done_pulse", dbg_done, 0);

      // Starvation under continuous CPU requests
      dbg_q.push_back(rom_f(10'd5));
      dbg_q.push_back(rom_f(10'd6));
      dbg_q.push_back(rom_f(10'd7));
      for (int k = 0; k < 16; k++) begin
         step();
         cpu_req   = 1'b1;
         cpu_addr  = AW'(100 + k);
         dbg_start = (k == 0);
         dbg_base  = 10'd5;
         dbg_len   = 11'd3;
         exp_stall = (k != 0) && (k % 5 == 0);
         if (!exp_stall) cpu_q.push_back(rom_f(AW'(100 + k)));
         @(negedge clk);
         check($sformatf("starve_stall_k%0d", k), cpu_stall, exp_stall);
      end
      step();
      cpu_req = 1'b0;
      wait_done(20, n);

      // Backpressure, len 4 with consumer stalled
      dbg_ready = 1'b0;
      cpu_addr  = 10'd999;
      for (int i = 20; i < 24; i++) dbg_q.push_back(rom_f(AW'(i)));
      start_burst(10'd20, 11'd4);
      repeat (8) step();
      @(negedge clk);
      check("bp_valid", dbg_valid, 1);
      check("bp_busy", dbg_busy, 1);
      check("bp_head", dbg_data, rom_f(10'd20));
      check("bp_no_fetch", rom_addr, 999);
      step();
      dbg_ready = 1'b1;
      wait_done(20, n);

      // Address wrap
      dbg_q.push_back(rom_f(10'd1022));
      dbg_q.push_back(rom_f(10'd1023));
      dbg_q.push_back(32'd538772480);
      start_burst(10'd1022, 11'd3);
      wait_done(20, n);

      // Zero length
      step();
      dbg_start = 1'b1;
      dbg_len   = 11'd0;
      @(negedge clk);
      check("len0_done_early", dbg_done, 0);
      step();
      dbg_start = 1'b0;
      @(negedge clk);
      check("len0_done", dbg_done, 1);
      check("len0_busy", dbg_busy, 0);
      step();
      @(negedge clk);
      check("len0_done_clear", dbg_done, 0);

      // Start during FETCH is ignored
      dbg_ready = 1'b0;
      for (int i = 40; i < 44; i++) dbg_q.push_back(rom_f(AW'(i)));
      start_burst(10'd40, 11'd4);
      step();
      dbg_start = 1'b1;
      dbg_base  = 10'd60;
      dbg_len   = 11'd2;
      step();
      dbg_start = 1'b0;
      step();
      dbg_ready = 1'b1;
      wait_done(20, n);
      @(negedge clk);
      check("ignored_busy", dbg_busy, 0);

      // Reset mid-burst after two words
      dbg_q.push_back(rom_f(10'd5));
      dbg_q.push_back(rom_f(10'd6));
      start_burst(10'd5, 11'd4);
      step();
      step();
      step();
      rst       = 1'b1;
      dbg_ready = 1'b0;
      dbg_q.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_cpu_valid", cpu_valid, 0);
      check("mid_rst_cpu_data", cpu_data, 0);
      check("mid_rst_dbg_valid", dbg_valid, 0);
      check("mid_rst_dbg_data", dbg_data, 0);
      check("mid_rst_dbg_busy", dbg_busy, 0);
      check("mid_rst_dbg_done", dbg_done, 0);
      step();
      @(negedge clk);
      check("mid_rst_no_done", dbg_done, 0);
      dbg_ready = 1'b1;
      dbg_q.push_back(32'd538772480);
      dbg_q.push_back(32'd537985031);
      start_burst(10'd0, 11'd2);
      wait_done(20, n);
      step();
      @(negedge clk);

      check("cpu_q_drained", cpu_q.size(), 0);
      check("dbg_q_drained", dbg_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/irom_fetch_arbiter.md
# irom_fetch_arbiter

Shares the single combinational instruction ROM (10-bit word address, 32-bit data) between the CPU fetch port and a debug burst-read port. The CPU has priority, and a starvation counter guarantees debug progress. Debug bursts stream sequential ROM words out through a 2-entry buffer with valid/ready backpressure. The block sits between the fetch stage and the ROM, with the debug side facing the UART/dump logic.

## Interface
Parameters:
- ADDR_W, 10: ROM word-address width.
- DATA_W, 32: ROM word width.
- STARVE_MAX, 4: consecutive lost debug arbitrations before debug is forced through; legal range 1..15.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU fetch request, level, sampled each cycle.
- cpu_addr  in  ADDR_W  CPU fetch word address.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_grant.
- cpu_data  out  DATA_W  registered fetch result.
- cpu_valid  out  1  registered: cpu_data holds the word granted last cycle.
- dbg_start  in  1  one-cycle burst start pulse; honoured only in IDLE.
- dbg_base  in  ADDR_W  burst start address, sampled with dbg_start.
- dbg_len  in  ADDR_W+1  burst length in words, 1..1024; 0 gives an immediate done.
- dbg_data  out  DATA_W  head of the debug buffer.
- dbg_valid  out  1  buffer non-empty.
- dbg_ready  in  1  consumer accepts dbg_data when dbg_valid & dbg_ready.
- dbg_busy  out  1  state != IDLE.
- dbg_done  out  1  one-cycle pulse at burst completion.
- rom_addr  out  ADDR_W  combinational: dbg_ptr when dbg_grant, else cpu_addr.
- rom_data  in  DATA_W  ROM output (combinational in rom_addr).

## Operation
- Debug wants a fetch (dbg_want) when state == FETCH, remaining != 0, and buffer count < 2, or count == 2 with a pop in the same cycle.
- Arbitration each cycle:
  - dbg_grant = dbg_want & (~cpu_req | starve_cnt == STARVE_MAX).
  - cpu_grant = cpu_req & ~dbg_grant.
- Starvation counter:
  - Increments when dbg_want & cpu_grant.
  - Clears on dbg_grant.
  - Holds otherwise, including when dbg_want is low.
- On cpu_grant: cpu_data <= rom_data and cpu_valid <= 1. With no grant, cpu_valid <= 0 and cpu_data holds its value.
- On dbg_grant: push rom_data into the buffer, dbg_ptr <= dbg_ptr+1 (wraps 1023 to 0), remaining <= remaining-1.
- FSM:
  - IDLE: dbg_start with dbg_len != 0 loads ptr and remaining, then goes to FETCH. dbg_start with dbg_len == 0 pulses dbg_done next cycle and stays in IDLE.
  - FETCH: the grant that makes remaining 0 moves to DRAIN.
  - DRAIN: buffer empty moves to IDLE with a dbg_done pulse in that cycle.
- dbg_start outside IDLE is ignored, with no side effects.
- Buffer behaviour:
  - Push and pop in the same cycle keep the count unchanged.
  - No push is allowed at count 2 without a pop.
  - Data order is preserved.

## Timing
- Reset values:
  - Outputs: cpu_valid 0, cpu_data 0, dbg_valid 0, dbg_data 0, dbg_busy 0, dbg_done 0.
  - Internal: state IDLE, starve_cnt 0, buffer empty.
  - rst mid-burst aborts the burst silently; no dbg_done is issued.
- CPU latency: grant in cycle N gives cpu_valid and cpu_data in cycle N+1. Back-to-back fetches give 1 word per cycle.
- Debug latency: grant in cycle N gives dbg_valid in cycle N+1 when the buffer was empty.
- Steady state with dbg_ready high and no CPU traffic: 1 word per cycle.
- Under continuous cpu_req, debug receives exactly 1 of every STARVE_MAX+1 cycles.
- dbg_done is issued the cycle after the last word is popped.

## Structure
- Shared package irom_arb_pkg holds:
  - State enum {IDLE, FETCH, DRAIN}.
  - ADDR_W and DATA_W defaults.
  - The STARVE_MAX legal-range constant.
- Sub-module irom_arb_fifo2: 2-entry synchronous FIFO with push/pop, count, head data, and synchronous reset.
- Arbitration, the counter, and the FSM live in the top module.

## Test plan
- CPU only: cpu_req held for addresses 0, 1, 2 → cpu_valid on the following cycles with data 538772480, 537985031, 538116127; cpu_stall stays 0.
- Debug only: base 5, len 3, dbg_ready=1 → dbg_data 538312848, 202375420, 202375394 on consecutive cycles; dbg_done one cycle after the last word; dbg_busy falls with it.
- Starvation (STARVE_MAX=4): continuous cpu_req plus a debug burst → cpu_stall high exactly every 5th cycle; each stall coincides with one debug word.
- Backpressure: len 4, dbg_ready=0 for 10 cycles → exactly 2 words buffered, no fetches, ptr frozen; releasing ready delivers all 4 words in order.
- Wrap and degenerate cases:
  - base 1022, len 3 → addresses 1022, 1023, 0; address 0 returns 538772480.
  - len 0 → dbg_done next cycle, dbg_busy stays 0.
  - dbg_start during FETCH → ignored.
- Reset mid-burst: assert rst after 2 words → all outputs at reset values next cycle, no dbg_done; a new burst then runs correctly.
